cam_trigger_gen: RTL and testbench

CAM_TRIGGER_GEN -- requirements
Module: cam_trigger_gen

---
 rtl/cam_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/cam_trigger_gen.sv | 129 ++++++++++++
 tb/tb_cam_trigger_gen.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera trigger generator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RUN  = 2'd2
  } cam_state_t;

  localparam int DEF_DIV       = 122;
  localparam int DEF_CHANNELS  = 1;
  localparam int DEF_DEB_TICKS = 16;
  localparam int DEF_POLL_W    = 16;
  localparam int DEF_TRIG_CH   = 0;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, tick-based debounce, rising-edge pulse.
// Latency: 2 clks sync + DEB_TICKS ticks to debounced; pressed one clk after that.
// Backpressure: none; free-running on tick enables.
module btn_debounce
  import cam_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic button,
  output logic debounced,
  output logic pressed
);

  localparam int CW = cnt_w(DEB_TICKS);

  logic [1:0]    sync;
  logic [CW-1:0] deb_cnt;
  logic          deb_d;

  // Bring the raw button into the clk domain before anything looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b00;
    else          sync <= {sync[0], button};
  end

  // Count consecutive ticks of disagreement; flip the level once it has held long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt   <= '0;
      debounced <= 1'b0;
    end else if (tick) begin
      if (sync[1] != debounced) begin
        if (deb_cnt == CW'(DEB_TICKS - 1)) begin
          debounced <= ~debounced;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Single-cycle pulse the clk after the debounced level rises; falls are silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      deb_d   <= debounced;
      pressed <= debounced & ~deb_d;
    end
  end

endmodule

// File: rtl/cam_trigger_gen.sv
// Camera capture trigger: debounced buttons and periodic poll feed a start/busy handshake.
// Latency: trigger to start is one clk; start holds until busy is seen.
// Backpressure: busy stalls requests; one extra trigger is queued, the rest coalesce.
module cam_trigger_gen
  import cam_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DEB_TICKS = DEF_DEB_TICKS,
  parameter int POLL_W    = DEF_POLL_W,
  parameter int TRIG_CH   = DEF_TRIG_CH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] button,
  input  logic                poll_en,
  input  logic [POLL_W-1:0]   poll_period,
  input  logic                busy,
  output logic                tick,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] pressed,
  output logic                start,
  output logic                pending
);

  localparam int TW = cnt_w(DIV - 1);

  logic [TW-1:0]     tick_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic [POLL_W:0]   poll_inc;
  logic              poll_active;
  logic              poll_hit;
  logic              trig;
  cam_state_t        state;
  cam_state_t        state_nxt;
  logic              pending_nxt;

  // Tick is decoded straight from the counter so it is exactly the DIV-1 cycle.
  assign tick = (tick_cnt == TW'(DIV - 1));

  // Free-running 0..DIV-1 prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_btn
      btn_debounce #(
        .DEB_TICKS(DEB_TICKS)
      ) u_btn_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .button   (button[g]),
        .debounced(debounced[g]),
        .pressed  (pressed[g])
      );
    end
  endgenerate

  // Poll fires on the tick where the count would reach the period; >= covers a period
  // lowered below the current count so polling never stalls.
  always_comb begin
    poll_active = poll_en && (poll_period != '0);
    poll_inc    = {1'b0, poll_cnt} + {{POLL_W{1'b0}}, 1'b1};
    poll_hit    = poll_active && tick && (poll_inc >= {1'b0, poll_period});
    trig        = pressed[TRIG_CH] | poll_hit;
  end

  // Poll counter: held at 0 when disabled, reloads to 0 on each poll trigger.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          poll_cnt <= '0;
    else if (!poll_active) poll_cnt <= '0;
    else if (tick)         poll_cnt <= poll_hit ? '0 : poll_inc[POLL_W-1:0];
  end

  // Handshake next-state: a trigger outside IDLE is queued once; a queued trigger
  // left behind when RUN drops to IDLE is consumed by IDLE like a fresh one.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      ST_IDLE: begin
        if (trig || pending) begin
          state_nxt   = ST_REQ;
          pending_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (busy) state_nxt = ST_RUN;
        if (trig) pending_nxt = 1'b1;
      end
      ST_RUN: begin
        if (!busy) begin
          if (pending) begin
            state_nxt   = ST_REQ;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
            if (trig) pending_nxt = 1'b1;
          end
        end else if (trig) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // State, pending and a registered start that mirrors the REQ state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      start   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      start   <= (state_nxt == ST_REQ);
    end
  end

endmodule

// File: tb/tb_cam_trigger_gen.sv
// Directed bench for cam_trigger_gen with DIV=4, DEB_TICKS=3, two buttons.
// Latency: n/a.
// Backpressure: busy is driven by the bench in place of the camera.
module tb_cam_trigger_gen;

  logic       clk;
  logic       reset_n;
  logic [1:0] button;
  logic       poll_en;
  logic [7:0] poll_period;
  logic       busy;
  logic       tick;
  logic [1:0] debounced;
  logic [1:0] pressed;
  logic       start;
  logic       pending;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cam_trigger_gen #(
    .DIV(4), .CHANNELS(2), .DEB_TICKS(3), .POLL_W(8), .TRIG_CH(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button(button), .poll_en(poll_en),
    .poll_period(poll_period), .busy(busy), .tick(tick), .debounced(debounced),
    .pressed(pressed), .start(start), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clk and land 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Align to the cycle in which tick is high (bounded).
  task automatic sync_to_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL sync_to_tick: tick=%b want 1 within 8 clks", tick);
    end
  endtask

  task automatic press0();
    button[0] = 1'b1;
    repeat (20) step();
    button[0] = 1'b0;
    repeat (20) step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; button = 2'b00; poll_en = 1'b0; poll_period = 8'd0; busy = 1'b0;
    repeat (3) step();
    checks += 5;
    if (tick !== 1'b0)       begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    if (debounced !== 2'b00) begin errors++; $display("FAIL reset_debounced: got %b want 00", debounced); end
    if (pressed !== 2'b00)   begin errors++; $display("FAIL reset_pressed: got %b want 00", pressed); end
    if (start !== 1'b0)      begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    if (pending !== 1'b0)    begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
  endtask

  task automatic test_tick();
    logic prev;
    logic exp;
    prev = 1'b0;
    reset_n = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp = ((n % 4) == 3);
      checks += 2;
      if (tick !== exp) begin
        errors++;
        $display("FAIL tick clk=%0d: got %b want %b", n, tick, exp);
      end
      if ((prev & tick) !== 1'b0) begin
        errors++;
        $display("FAIL tick_consecutive clk=%0d: got %b want 0", n, prev & tick);
      end
      prev = tick;
    end
  endtask

  task automatic test_bounce();
    sync_to_tick();
    for (int k = 0; k < 6; k++) begin
      button[0] = ((k % 2) == 0);
      repeat (4) begin
        step();
        checks += 2;
        if (debounced[0] !== 1'b0) begin
          errors++; $display("FAIL bounce_debounced k=%0d: got %b want 0", k, debounced[0]);
        end
        if (pressed[0] !== 1'b0) begin
          errors++; $display("FAIL bounce_pressed k=%0d: got %b want 0", k, pressed[0]);
        end
      end
    end
  endtask

  // Button held from a tick-aligned point: debounced at +13 clks, pressed at +14, start at +15.
  task automatic test_debounce_hold();
    int pulses;
    pulses = 0;
    button[0] = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (pressed[0]) pulses++;
      checks += 3;
      if (debounced[0] !== (n >= 13)) begin
        errors++; $display("FAIL hold_debounced clk=%0d: got %b want %b", n, debounced[0], n >= 13);
      end
      if (pressed[0] !== (n == 14)) begin
        errors++; $display("FAIL hold_pressed clk=%0d: got %b want %b", n, pressed[0], n == 14);
      end
      if (start !== (n >= 15)) begin
        errors++; $display("FAIL hold_start clk=%0d: got %b want %b", n, start, n >= 15);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_handshake();
    int drops;
    drops = 0;
    busy = 1'b0;
    repeat (50) begin
      step();
      if (start !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL handshake_hold: got %0d drops want 0", drops); end
    busy = 1'b1;
    step();
    checks += 2;
    if (start !== 1'b0)   begin errors++; $display("FAIL handshake_drop: got %b want 0", start); end
    if (pending !== 1'b0) begin errors++; $display("FAIL handshake_pending: got %b want 0", pending); end
    busy = 1'b0;
    repeat (3) step();
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL handshake_idle: got %b want 0", start); end
  endtask

  task automatic test_release();
    sync_to_tick();
    button[0] = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      checks += 3;
      if (debounced[0] !== (n < 13)) begin
        errors++; $display("FAIL release_debounced clk=%0d: got %b want %b", n, debounced[0], n < 13);
      end
      if (pressed[0] !== 1'b0) begin
        errors++; $display("FAIL release_pressed clk=%0d: got %b want 0", n, pressed[0]);
      end
      if (start !== 1'b0) begin
        errors++; $display("FAIL release_start clk=%0d: got %b want 0", n, start);
      end
    end
  endtask

  task automatic test_other_channel();
    int pulses;
    int starts;
    pulses = 0; starts = 0;
    button[1] = 1'b1;
    repeat (40) begin step(); if (pressed[1]) pulses++; if (start) starts++; end
    button[1] = 1'b0;
    repeat (40) begin step(); if (pressed[1]) pulses++; if (start) starts++; end
    checks += 3;
    if (pulses != 1)           begin errors++; $display("FAIL ch1_pulses: got %0d want 1", pulses); end
    if (starts != 0)           begin errors++; $display("FAIL ch1_start: got %0d want 0", starts); end
    if (debounced[1] !== 1'b0) begin errors++; $display("FAIL ch1_debounced: got %b want 0", debounced[1]); end
  endtask

  task automatic test_busy_idle();
    int starts;
    starts = 0;
    busy = 1'b1;
    repeat (20) begin step(); if (start || pending) starts++; end
    busy = 1'b0;
    step();
    checks++;
    if (starts != 0) begin errors++; $display("FAIL busy_idle: got %0d active cycles want 0", starts); end
  endtask

  task automatic test_coalesce();
    int rises;
    logic prev;
    busy = 1'b0;
    press0();
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL coalesce_first_start: got %b want 1", start); end
    busy = 1'b1;
    step();
    checks += 2;
    if (start !== 1'b0)   begin errors++; $display("FAIL coalesce_run_start: got %b want 0", start); end
    if (pending !== 1'b0) begin errors++; $display("FAIL coalesce_run_pending: got %b want 0", pending); end
    repeat (3) press0();
    checks += 2;
    if (pending !== 1'b1) begin errors++; $display("FAIL coalesce_pending: got %b want 1", pending); end
    if (start !== 1'b0)   begin errors++; $display("FAIL coalesce_start_in_run: got %b want 0", start); end
    busy = 1'b0;
    step();
    checks += 2;
    if (start !== 1'b1)   begin errors++; $display("FAIL coalesce_restart: got %b want 1", start); end
    if (pending !== 1'b0) begin errors++; $display("FAIL coalesce_pending_clear: got %b want 0", pending); end
    busy = 1'b1;
    step();
    busy = 1'b0;
    step();
    rises = 0; prev = start;
    repeat (60) begin
      step();
      if (start && !prev) rises++;
      prev = start;
    end
    checks += 2;
    if (rises != 0)       begin errors++; $display("FAIL coalesce_extra_start: got %0d want 0", rises); end
    if (pending !== 1'b0) begin errors++; $display("FAIL coalesce_final_pending: got %b want 0", pending); end
  endtask

  task automatic test_poll();
    int t[4];
    int found;
    int guard;
    int starts;
    found = 0; guard = 0;
    poll_period = 8'd5;
    poll_en = 1'b1;
    while (found < 4 && guard < 300) begin
      step();
      guard++;
      if (start) begin
        t[found] = cyc;
        found++;
        busy = 1'b1;
        repeat (8) step();
        busy = 1'b0;
      end
    end
    checks++;
    if (found != 4) begin errors++; $display("FAIL poll_count: got %0d starts want 4", found); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (found == 4 && (t[i] - t[i-1]) != 20) begin
        errors++; $display("FAIL poll_interval %0d: got %0d clks want 20", i, t[i] - t[i-1]);
      end
    end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL poll_pending: got %b want 0", pending); end
    step();
    poll_period = 8'd0;
    starts = 0;
    repeat (60) begin step(); if (start) starts++; end
    checks++;
    if (starts != 0) begin errors++; $display("FAIL poll_disabled: got %0d start cycles want 0", starts); end
    poll_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    int starts;
    n = 0;
    button[0] = 1'b1;
    while (start !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (start !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_req: got %b want 1", start); end
    button[0] = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (start !== 1'b0)        begin errors++; $display("FAIL rst_mid_start: got %b want 0", start); end
    if (pending !== 1'b0)      begin errors++; $display("FAIL rst_mid_pending: got %b want 0", pending); end
    if (debounced !== 2'b00)   begin errors++; $display("FAIL rst_mid_debounced: got %b want 00", debounced); end
    repeat (2) step();
    reset_n = 1'b1;
    starts = 0;
    repeat (60) begin step(); if (start) starts++; end
    checks++;
    if (starts != 0) begin errors++; $display("FAIL rst_mid_no_start: got %0d start cycles want 0", starts); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_bounce();
    test_debounce_hold();
    test_handshake();
    test_release();
    test_other_channel();
    test_busy_idle();
    test_coalesce();
    test_poll();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
